// File: rtl/dram_model_pkg.sv
// Shared types, constants and command decode for the DRAM behavioural model.
package dram_model_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam int unsigned DEF_ROW_BITS = 11;
    localparam int unsigned DEF_COL_BITS = 10;
    localparam int unsigned DEF_T_RCD    = 5;
    localparam int unsigned DEF_CL       = 5;
    localparam int unsigned DEF_T_RP     = 5;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_ACT_ACTIVE  = 3'd1;
    localparam logic [2:0] ERR_IDLE_ACCESS = 3'd2;
    localparam logic [2:0] ERR_TRCD        = 3'd3;
    localparam logic [2:0] ERR_TRP         = 3'd4;
    localparam logic [2:0] ERR_ILLEGAL     = 3'd5;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_READ,
        CMD_WRITE,
        CMD_PRE,
        CMD_ILLEGAL
    } cmd_e;

    typedef enum logic {
        BANK_IDLE,
        BANK_ACTIVE
    } bank_e;

    // Map the raw control pins onto a command; chip deselect is always NOP.
    function automatic cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                        input logic cas_n, input logic [BE_W-1:0] we_n);
        cmd_e c;
        c = CMD_NOP;
        if (!cs_n) begin
            case ({ras_n, cas_n})
                2'b11:   c = CMD_NOP;
                2'b01:   c = (we_n == '1) ? CMD_ACT :
                             (we_n == '0) ? CMD_PRE : CMD_ILLEGAL;
                2'b10:   c = (we_n == '1) ? CMD_READ : CMD_WRITE;
                default: c = CMD_ILLEGAL;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/dram_model_rd_pipe.sv
// Read-latency delay line: valid bits are reset, data bits are not.
module dram_rd_pipe #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned WIDTH = 32
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH:0]   vld_shift;
    logic [WIDTH-1:0] dat [DEPTH];

    // Shifted view of the valid chain with the new entry appended at bit 0.
    always_comb begin
        vld_shift = {vld, in_valid};
    end

    // Valid chain, flushed by reset so in-flight reads vanish.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            vld <= '0;
        end else begin
            vld <= vld_shift[DEPTH-1:0];
        end
    end

    // Data chain follows the valid chain without reset.
    always_ff @(posedge ACLK) begin
        dat[0] <= in_data;
        for (int i = 1; i < int'(DEPTH); i++) begin
            dat[i] <= dat[i-1];
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/dram_model.sv
// Single-bank DRAM device model: command decode, open-row tracking,
// tRCD/tRP/CL timing and sticky protocol-violation reporting.
module dram_model
    import dram_model_pkg::*;
#(
    parameter int unsigned ROW_BITS = DEF_ROW_BITS,
    parameter int unsigned COL_BITS = DEF_COL_BITS,
    parameter int unsigned T_RCD    = DEF_T_RCD,
    parameter int unsigned CL       = DEF_CL,
    parameter int unsigned T_RP     = DEF_T_RP
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              CSn,
    input  logic              RASn,
    input  logic              CASn,
    input  logic [BE_W-1:0]   WEn,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q,
    output logic              VALID,
    output logic              err,
    output logic [2:0]        err_code
);

    localparam int unsigned AW    = ROW_BITS + COL_BITS;
    localparam int unsigned RCD_W = $clog2(T_RCD + 2);
    localparam int unsigned RP_W  = $clog2(T_RP + 2);

    logic [DATA_W-1:0] mem [0:(2**AW)-1];

    cmd_e              cmd;
    bank_e             state, state_nxt;
    logic [ROW_BITS-1:0] row;
    logic [RCD_W-1:0]  rcd_cnt;
    logic [RP_W-1:0]   rp_cnt;
    logic              rcd_ok, rp_ok;
    logic              act_go, pre_go, rd_go, wr_go;
    logic              viol;
    logic [2:0]        viol_code;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] rd_word;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;

    assign cmd     = decode_cmd(CSn, RASn, CASn, WEn);
    assign rcd_ok  = rcd_cnt >= RCD_W'(T_RCD);
    assign rp_ok   = rp_cnt  >= RP_W'(T_RP);
    assign addr    = {row, A[COL_BITS-1:0]};
    assign rd_word = mem[addr];

    // Bank state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= BANK_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command legality check and bank next-state; violating commands do nothing.
    always_comb begin
        state_nxt = state;
        act_go    = 1'b0;
        pre_go    = 1'b0;
        rd_go     = 1'b0;
        wr_go     = 1'b0;
        viol      = 1'b0;
        viol_code = ERR_NONE;
        case (cmd)
            CMD_ACT: begin
                if (state == BANK_ACTIVE) begin
                    viol      = 1'b1;
                    viol_code = ERR_ACT_ACTIVE;
                end else if (!rp_ok) begin
                    viol      = 1'b1;
                    viol_code = ERR_TRP;
                end else begin
                    act_go    = 1'b1;
                    state_nxt = BANK_ACTIVE;
                end
            end
            CMD_PRE: begin
                pre_go    = 1'b1;
                state_nxt = BANK_IDLE;
            end
            CMD_READ, CMD_WRITE: begin
                if (state == BANK_IDLE) begin
                    viol      = 1'b1;
                    viol_code = ERR_IDLE_ACCESS;
                end else if (!rcd_ok) begin
                    viol      = 1'b1;
                    viol_code = ERR_TRCD;
                end else begin
                    rd_go = (cmd == CMD_READ);
                    wr_go = (cmd == CMD_WRITE);
                end
            end
            CMD_ILLEGAL: begin
                viol      = 1'b1;
                viol_code = ERR_ILLEGAL;
            end
            default: ;
        endcase
    end

    // Open row, saturating timing counters (reset to satisfied) and sticky error.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            row      <= '0;
            rcd_cnt  <= RCD_W'(T_RCD);
            rp_cnt   <= RP_W'(T_RP);
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            if (act_go) begin
                row     <= A[ROW_BITS-1:0];
                rcd_cnt <= RCD_W'(1);
            end else if (!rcd_ok) begin
                rcd_cnt <= rcd_cnt + 1'b1;
            end
            if (pre_go) begin
                rp_cnt <= RP_W'(1);
            end else if (!rp_ok) begin
                rp_cnt <= rp_cnt + 1'b1;
            end
            if (viol && !err) begin
                err      <= 1'b1;
                err_code <= viol_code;
            end
        end
    end

    // Byte-masked array write; the array is never reset.
    always_ff @(posedge ACLK) begin
        if (wr_go) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (!WEn[i]) begin
                    mem[addr][8*i +: 8] <= D[8*i +: 8];
                end
            end
        end
    end

    dram_rd_pipe #(
        .DEPTH (CL),
        .WIDTH (DATA_W)
    ) u_rd_pipe (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .in_valid  (rd_go),
        .in_data   (rd_word),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    // Output stage: strobe for one cycle, hold last data otherwise.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            VALID <= 1'b0;
            Q     <= '0;
        end else begin
            VALID <= pipe_valid;
            if (pipe_valid) begin
                Q <= pipe_data;
            end
        end
    end

endmodule

// File: tb/tb_dram_model.sv
// Scoreboard bench for dram_model: reads push expected data and arrival edge.
module tb_dram_model;

    localparam int CL_T = 5;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        CSn, RASn, CASn;
    logic [3:0]  WEn;
    logic [10:0] A;
    logic [31:0] D;
    logic [31:0] Q;
    logic        VALID;
    logic        err;
    logic [2:0]  err_code;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   edge_cnt = 0;

    dram_model dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .CSn      (CSn),
        .RASn     (RASn),
        .CASn     (CASn),
        .WEn      (WEn),
        .A        (A),
        .D        (D),
        .Q        (Q),
        .VALID    (VALID),
        .err      (err),
        .err_code (err_code)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every VALID must match the oldest expectation in data and edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge ACLK);
            #1;
            if (VALID === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(VALID), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rd_data", Q, e.data);
                    check("rd_edge", 32'(edge_cnt), 32'(e.due));
                end
            end
        end
    end

    // One command per clock edge; pins return to NOP just after the edge.
    task automatic pins(input logic csn, input logic rasn, input logic casn,
                        input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d,
                        input bit push, input logic [31:0] exp);
        @(negedge ACLK);
        CSn = csn; RASn = rasn; CASn = casn; WEn = wen; A = a; D = d;
        @(posedge ACLK);
        #1;
        if (push) sb.push_back('{exp, edge_cnt + CL_T});
        CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF;
    endtask

    task automatic nop(input int n);
        repeat (n) pins(1'b1, 1'b1, 1'b1, 4'hF, 11'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic act(input logic [10:0] r);
        pins(1'b0, 1'b0, 1'b1, 4'hF, r, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic pre();
        pins(1'b0, 1'b0, 1'b1, 4'h0, 11'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic wr(input logic [10:0] c, input logic [31:0] d, input logic [3:0] wen);
        pins(1'b0, 1'b1, 1'b0, wen, c, d, 1'b0, 32'd0);
    endtask

    task automatic rd(input logic [10:0] c, input bit push, input logic [31:0] exp);
        pins(1'b0, 1'b1, 1'b0, 4'hF, c, 32'd0, push, exp);
    endtask

    initial begin
        ARESETn = 1'b0;
        CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF; A = '0; D = '0;
        repeat (3) @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check("reset_q", Q, 32'd0);
        check("reset_valid", 32'(VALID), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_err_code", 32'(err_code), 32'd0);

        // Full write then read at the earliest legal edges.
        act(11'h003);
        nop(4);
        wr(11'h010, 32'hDEADBEEF, 4'h0);
        rd(11'h010, 1'b1, 32'hDEADBEEF);

        // Low byte only.
        wr(11'h010, 32'h000000AA, 4'b1110);
        rd(11'h010, 1'b1, 32'hDEADBEAA);

        // Back-to-back reads.
        wr(11'h000, 32'hC0DE0000, 4'h0);
        wr(11'h001, 32'hC0DE0001, 4'h0);
        wr(11'h002, 32'hC0DE0002, 4'h0);
        wr(11'h003, 32'hC0DE0003, 4'h0);
        rd(11'h000, 1'b1, 32'hC0DE0000);
        rd(11'h001, 1'b1, 32'hC0DE0001);
        rd(11'h002, 1'b1, 32'hC0DE0002);
        rd(11'h003, 1'b1, 32'hC0DE0003);
        nop(8);
        check("q_hold", Q, 32'hC0DE0003);
        check("valid_idle", 32'(VALID), 32'd0);
        check("no_err_yet", 32'(err), 32'd0);

        // READ one edge before tRCD is met.
        pre();
        nop(4);
        act(11'h003);
        nop(3);
        rd(11'h010, 1'b0, 32'd0);
        check("trcd_err", 32'(err), 32'd1);
        check("trcd_code", 32'(err_code), 32'd3);
        nop(8);

        // Reset clears err; then ACT before tRP, then legal ACT.
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        check("rst_err_clear", 32'(err), 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        pre();
        nop(2);
        act(11'h003);
        check("trp_err", 32'(err), 32'd1);
        check("trp_code", 32'(err_code), 32'd4);
        nop(1);
        act(11'h003);
        nop(4);
        rd(11'h010, 1'b1, 32'hDEADBEAA);
        nop(7);
        check("code_sticky", 32'(err_code), 32'd4);

        // Reset with two reads in flight.
        rd(11'h010, 1'b0, 32'd0);
        rd(11'h011, 1'b0, 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        check("flush_valid", 32'(VALID), 32'd0);
        check("flush_err", 32'(err), 32'd0);
        repeat (3) @(negedge ACLK);
        ARESETn = 1'b1;
        rd(11'h010, 1'b0, 32'd0);
        check("idle_err", 32'(err), 32'd1);
        check("idle_code", 32'(err_code), 32'd2);
        nop(10);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
